// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared constants, state enum and index/count types for the adder tree feeder
package adder_tree_pkg;

   localparam int ADDER_WIDTH  = 64;
   localparam int LANES        = 8;
   localparam int TREE_LATENCY = 2;

   // Wide enough to hold 0..TREE_LATENCY
   localparam int WCNT_W = 2;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } feeder_state_e;

   typedef logic [2:0]        lane_idx_t;
   typedef logic [3:0]        count_t;
   typedef logic [WCNT_W-1:0] wcnt_t;

   localparam lane_idx_t LAST_LANE    = lane_idx_t'(LANES - 1);
   localparam wcnt_t     WCNT_EXPIRED = wcnt_t'(TREE_LATENCY);

   // Number of real operands in a group that closed on lane idx
   function automatic count_t idx_to_count(lane_idx_t idx);
      return {1'b0, idx} + count_t'(1);
   endfunction

endpackage

// File: rtl/adder_tree_lane_bank.sv
// rtl/adder_tree_lane_bank.sv - LANES x WIDTH operand registers with indexed write and zero padding
module adder_tree_lane_bank
   import adder_tree_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic                   clk,
   input  logic                   clr_i,
   input  logic                   wr_en_i,
   input  lane_idx_t              wr_idx_i,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic                   pad_i,
   output logic [LANES*WIDTH-1:0] lanes_o
);

   logic [WIDTH-1:0] lane_q [LANES];

   // Write the addressed lane; on a padded close also zero every lane above it
   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int k = 0; k < LANES; k++) begin
            lane_q[k] <= '0;
         end
      end else if (wr_en_i) begin
         for (int k = 0; k < LANES; k++) begin
            if (k == int'(wr_idx_i)) begin
               lane_q[k] <= wr_data_i;
            end else if (pad_i && (k > int'(wr_idx_i))) begin
               lane_q[k] <= '0;
            end
         end
      end
   end

   // Flatten the bank onto the tree operand bus, lane k at [k*WIDTH +: WIDTH]
   for (genvar g = 0; g < LANES; g++) begin : g_flat
      assign lanes_o[g*WIDTH +: WIDTH] = lane_q[g];
   end

endmodule

// File: rtl/adder_tree_feeder.sv
// rtl/adder_tree_feeder.sv - packs a serial operand stream into tree lanes and returns the tree sum
module adder_tree_feeder
   import adder_tree_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_last,
   output logic [LANES*WIDTH-1:0] lanes_o,
   input  logic [WIDTH:0]         sum_i,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [WIDTH:0]         result_data,
   output logic [3:0]             result_count
);

   feeder_state_e  state_q;
   lane_idx_t      idx_q;
   count_t         count_q;
   wcnt_t          wcnt_q;
   logic           result_valid_q;
   logic [WIDTH:0] result_data_q;
   count_t         result_count_q;

   logic accept;
   logic close;

   // Ready depends on state only; held low through reset so no word is taken mid-reset
   assign in_ready = (state_q == FILL) && !rst;
   assign accept   = in_valid && in_ready;
   assign close    = in_last || (idx_q == LAST_LANE);

   adder_tree_lane_bank #(
      .WIDTH (WIDTH)
   ) u_lane_bank (
      .clk       (clk),
      .clr_i     (rst),
      .wr_en_i   (accept),
      .wr_idx_i  (idx_q),
      .wr_data_i (in_data),
      .pad_i     (in_last),
      .lanes_o   (lanes_o)
   );

   // Sequencing FSM: fill lanes, wait out the tree pipeline, hold the captured sum
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= FILL;
         idx_q          <= '0;
         count_q        <= '0;
         wcnt_q         <= '0;
         result_valid_q <= 1'b0;
         result_data_q  <= '0;
         result_count_q <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  if (close) begin
                     count_q <= idx_to_count(idx_q);
                     wcnt_q  <= '0;
                     state_q <= WAIT;
                  end else begin
                     idx_q <= idx_q + lane_idx_t'(1);
                  end
               end
            end
            WAIT: begin
               if (wcnt_q == WCNT_EXPIRED) begin
                  result_data_q  <= sum_i;
                  result_count_q <= count_q;
                  result_valid_q <= 1'b1;
                  state_q        <= HOLD;
               end else begin
                  wcnt_q <= wcnt_q + wcnt_t'(1);
               end
            end
            HOLD: begin
               if (result_ready) begin
                  result_valid_q <= 1'b0;
                  idx_q          <= '0;
                  state_q        <= FILL;
               end
            end
            default: begin
               state_q <= FILL;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign result_valid = result_valid_q;
   assign result_data  = result_data_q;
   assign result_count = result_count_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb/tb_adder_tree_feeder.sv - scoreboard bench for adder_tree_feeder with a two-stage tree model
module tb_adder_tree_feeder;
   import adder_tree_pkg::*;

   localparam int W = ADDER_WIDTH;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       in_data;
   logic               in_last;
   logic [LANES*W-1:0] lanes_o;
   logic [W:0]         sum_i;
   logic               result_valid;
   logic               result_ready;
   logic [W:0]         result_data;
   logic [3:0]         result_count;

   always #5 clk = ~clk;

   adder_tree_feeder dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .lanes_o      (lanes_o),
      .sum_i        (sum_i),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_data  (result_data),
      .result_count (result_count)
   );

   // Tree model: input register, then registered 65-bit sum
   logic [LANES*W-1:0] tree_in_q;
   logic [W:0]         tree_sum_q;

   function automatic logic [W:0] lane_sum(logic [LANES*W-1:0] v);
      logic [W:0] s;
      s = '0;
      for (int k = 0; k < LANES; k++) s = s + {1'b0, v[k*W +: W]};
      return s;
   endfunction

   always @(posedge clk) begin
      tree_in_q  <= lanes_o;
      tree_sum_q <= lane_sum(tree_in_q);
   end
   assign sum_i = tree_sum_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [W:0] data;
      logic [3:0] count;
   } exp_t;
   exp_t sb[$];

   int last_acc_cyc = 0;
   int rise_cyc     = 0;

   task automatic check(string name, logic [W:0] act, logic [W:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(logic [W:0] d, logic [3:0] c);
      exp_t e;
      e.data  = d;
      e.count = c;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send_word(logic [W-1:0] d, logic last);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", 0, 1);
      end else begin
         @(posedge clk);
         #1 last_acc_cyc = cyc;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   // Monitor: pop and compare on each handshake; also checks hold stability under backpressure
   logic       prev_valid   = 1'b0;
   logic       hold_pending = 1'b0;
   logic [W:0] hold_data;
   logic [3:0] hold_count;

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst) begin
         prev_valid   = 1'b0;
         hold_pending = 1'b0;
      end else begin
         if (result_valid && !prev_valid) rise_cyc = cyc;
         if (result_valid) begin
            if (hold_pending) begin
               check("hold_data_stable", result_data, hold_data);
               check("hold_count_stable", {61'd0, result_count}, {61'd0, hold_count});
            end
            if (result_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("result_data", result_data, e.data);
                  check("result_count", {61'd0, result_count}, {61'd0, e.count});
               end
               hold_pending = 1'b0;
            end else begin
               hold_pending = 1'b1;
               hold_data    = result_data;
               hold_count   = result_count;
            end
         end else begin
            hold_pending = 1'b0;
         end
         prev_valid = result_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c;
      rst          = 1'b1;
      result_ready = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_in_ready", in_ready, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_result_data", result_data, 0);
      check("rst_result_count", {61'd0, result_count}, 0);
      check("rst_lanes_lo", lanes_o[W:0], 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_release", in_ready, 1);

      // Full group 1..8
      push_exp(65'd36, 4'd8);
      for (int i = 1; i <= 8; i++) send_word(W'(i), 1'b0);
      idle_inputs();
      n = 0;
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("full_ready_low_cycles", n, 4);
      check("full_latency", rise_cyc - last_acc_cyc, 3);
      drain();

      // Short group: lanes 3..7 still hold 4..8 from the full group before the close
      push_exp(65'h60, 4'd3);
      send_word(64'h10, 1'b0);
      send_word(64'h20, 1'b0);
      send_word(64'h30, 1'b1);
      idle_inputs();
      check("short_lane0", lanes_o[0*W +: W], 64'h10);
      check("short_lane2", lanes_o[2*W +: W], 64'h30);
      for (int k = 3; k < LANES; k++) check("short_pad_lane", lanes_o[k*W +: W], 0);
      drain();

      // Wrap: 8 x all-ones, sum modulo 2^65
      push_exp(65'h1_FFFF_FFFF_FFFF_FFF8, 4'd8);
      for (int i = 0; i < 8; i++) send_word({W{1'b1}}, 1'b0);
      idle_inputs();
      drain();

      // Backpressure, then single-word group offered during HOLD
      result_ready = 1'b0;
      push_exp(65'd6, 4'd3);
      send_word(64'd1, 1'b0);
      send_word(64'd2, 1'b0);
      send_word(64'd3, 1'b1);
      idle_inputs();
      n = 0;
      while (!result_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("bp_valid_seen", result_valid, 1);
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready_low", in_ready, 0);
         check("bp_valid_held", result_valid, 1);
         @(negedge clk);
      end
      result_ready = 1'b1;
      push_exp(65'd5, 4'd1);
      c = cyc;
      send_word(64'd5, 1'b1);
      idle_inputs();
      check("bp_next_accept_cycle", last_acc_cyc, c + 2);
      drain();

      // Reset after 5 accepts: partial group discarded
      for (int i = 0; i < 5; i++) send_word(W'(i + 11), 1'b0);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      check("midgrp_in_ready_in_rst", in_ready, 0);
      for (int k = 0; k < LANES; k++) check("midgrp_lane_zero", lanes_o[k*W +: W], 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset during WAIT: no result may appear
      for (int i = 0; i < 8; i++) send_word(W'(i + 21), 1'b0);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < LANES; k++) check("midwait_lane_zero", lanes_o[k*W +: W], 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (result_valid) n++;
      end
      check("midwait_no_result", n, 0);

      push_exp(65'd16, 4'd2);
      send_word(64'd7, 1'b0);
      send_word(64'd9, 1'b1);
      idle_inputs();
      drain();

      repeat (4) @(negedge clk);
      check("sb_empty_end", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
